gate_tt_bist: RTL
=================

// Module: gate_tt_bist
// PURPOSE
//  Hardware truth-table exerciser for small combinational gates (nand_gate and peers).
//  Drives every input pattern to the gate under test, waits for it to settle, and samples
//  the gate output. Compares each sample against an expected truth table and reports
//  pass/fail, a mismatch count and the first failing pattern.
//  Sits between a test controller (start/done handshake) and one gate instance.
// PARAMETERS
//  N_IN    2  number of gate inputs; patterns = 2**N_IN; legal 1..4
//  SETTLE  1  cycles each pattern is held before sampling; legal >= 1
// PORTS
//  clk          in   1         single clock; all logic on rising edge
//  rst_n        in   1         asynchronous active-low reset
//  start        in   1         run request; sampled only in IDLE
//  exp_tt       in   2**N_IN   expected output; bit i = gate output for pattern i
//  dut_y        in   1         gate-under-test output
//  stim         out  N_IN      gate inputs; for nand_gate: stim[1]=a, stim[0]=b
//  busy         out  1         high from the cycle after start is accepted until done
//  done         out  1         one-cycle pulse at end of run
//  pass         out  1         1 = last run had zero mismatches; held until next start
//  err_cnt      out  N_IN+1    mismatches in last run; held until next start
//  fail_valid   out  1         at least one mismatch in last run
//  first_fail   out  N_IN      index of first mismatching pattern; valid when fail_valid
// BEHAVIOUR
//  Reset (async assert, sync-release by design): state=IDLE. stim, busy, done, pass,
//   err_cnt, fail_valid and first_fail all 0.
//  FSM states: IDLE, DRIVE, CHECK, DONE.
//   IDLE  start=1 -> latch exp_tt to exp_q, idx=0, stim=0, settle cnt=0, clear err_cnt,
//         pass, fail_valid and first_fail -> DRIVE. start=0 -> stay; stim=0.
//   DRIVE stim=idx; hold SETTLE cycles, then -> CHECK.
//   CHECK sample dut_y. If dut_y != exp_q[idx]: err_cnt+1; if fail_valid=0, then
//         first_fail=idx and fail_valid=1. If idx = 2**N_IN-1 -> DONE.
//         Otherwise idx+1, stim=idx+1 -> DRIVE.
//   DONE  done=1 for one cycle; pass=(err_cnt==0) registered here; busy=0 -> IDLE.
//  Timing: start high at edge E0 gives done high in cycle 2**N_IN*(SETTLE+1)+1.
//   Example: N_IN=2, SETTLE=1 -> 9 cycles. stim changes only on DRIVE entry.
//  Boundaries:
//   - start while busy or in DONE: ignored (no queuing).
//   - exp_tt changing mid-run: no effect; the run uses exp_q.
//   - err_cnt max = 2**N_IN; the width guarantees no overflow. No wrap.
//   - idx wraps never; the run ends at the last pattern.
//   - rst_n low mid-run: immediate return to reset values; no done pulse.
//   - start high continuously: back-to-back runs with one IDLE cycle between DONE and
//     the next DRIVE.
//   - dut_y X/Z: treated as mismatch (compare with !==).
// STRUCTURE
//  gate_tt_bist_pkg: state encoding localparams (IDLE=0, DRIVE=1, CHECK=2, DONE=3) and
//   the legal-range limits for N_IN and SETTLE.
//  Sub-module gate_tt_settle_tmr: loadable down-counter giving a one-cycle expire pulse
//   after SETTLE cycles; FSM restarts it on every DRIVE entry.
//  Top holds the FSM, idx, exp_q and result registers. Elaboration check fails on an
//   illegal parameter.
// TESTING (bench instantiates nand_gate as the gate under test; N_IN=2, SETTLE=1)
//  1. Reset held 3 cycles, then released -> all outputs 0, busy=0.
//  2. exp_tt=4'b0111, one start pulse -> stim sequence 0,1,2,3; done at cycle 9;
//     pass=1, err_cnt=0, fail_valid=0.
//  3. exp_tt=4'b1000 (AND table) vs nand_gate -> pass=0, err_cnt=4, first_fail=0,
//     fail_valid=1.
//  4. exp_tt=4'b1111 -> only pattern 3 fails: err_cnt=1, first_fail=3.
//  5. start re-pulsed at cycle 4 of a run, and exp_tt flipped to 4'b0000 mid-run ->
//     run unaffected: done at cycle 9, pass=1.
//  6. rst_n pulsed low at cycle 5 -> outputs 0 at once, no done; a new start then
//     completes normally with pass=1.

Source files
------------

// File: rtl/gate_tt_bist_pkg.sv
// Shared definitions for the gate truth-table exerciser: FSM encoding and legal
// parameter ranges.
package gate_tt_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int N_IN_MIN   = 1;
   localparam int N_IN_MAX   = 4;
   localparam int SETTLE_MIN = 1;

endpackage

// File: rtl/gate_tt_settle_tmr.sv
// Loadable settle timer: load starts a countdown; expire pulses for one cycle
// SETTLE cycles after the load edge.
module gate_tt_settle_tmr #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expire
);

   localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [W-1:0] LOAD_VAL = W'(SETTLE - 1);

   logic [W-1:0] cnt;
   logic         active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         active <= 1'b0;
      end else if (load) begin
         cnt    <= LOAD_VAL;
         active <= 1'b1;
      end else if (active) begin
         if (cnt == '0) active <= 1'b0;
         else           cnt    <= cnt - 1'b1;
      end
   end

   assign expire = active && (cnt == '0);

endmodule

// File: rtl/nand_gate.sv
// Two-input NAND used as the gate under test for the truth-table exerciser.
module nand_gate (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = ~(a & b);

endmodule

// File: rtl/gate_tt_bist.sv
// Truth-table exerciser: walks every input pattern into a small gate, samples
// its output after a settle delay and reports pass, mismatch count and first failure.
//
// state | meaning
// IDLE  | waiting for start; stim held at 0
// DRIVE | stim = idx, waiting for the settle timer
// CHECK | compare dut_y with exp_q[idx]; advance or finish
// DONE  | one-cycle done pulse; pass registered
module gate_tt_bist
   import gate_tt_bist_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [(1<<N_IN)-1:0]   exp_tt,
   input  logic                   dut_y,
   output logic [N_IN-1:0]        stim,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          err_cnt,
   output logic                   fail_valid,
   output logic [N_IN-1:0]        first_fail
);

   if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || SETTLE < SETTLE_MIN) begin : g_bad_param
      $error("gate_tt_bist: illegal N_IN or SETTLE");
   end

   localparam logic [N_IN-1:0] IDX_LAST = '1;

   state_t                 state, state_nxt;
   logic [N_IN-1:0]        idx;
   logic [(1<<N_IN)-1:0]   exp_q;
   logic                   tmr_load;
   logic                   tmr_expire;
   logic                   mismatch;

   gate_tt_settle_tmr #(.SETTLE(SETTLE)) u_settle_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load),
      .expire (tmr_expire)
   );

   // X/Z on the gate output must count as a failure, hence the 4-state compare.
   assign mismatch = (dut_y !== exp_q[idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_DRIVE;
               tmr_load  = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (tmr_expire) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (idx == IDX_LAST) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_DRIVE;
               tmr_load  = 1'b1;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         exp_q      <= '0;
         stim       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         first_fail <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               stim <= '0;
               if (start) begin
                  exp_q      <= exp_tt;
                  idx        <= '0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  err_cnt    <= '0;
                  fail_valid <= 1'b0;
                  first_fail <= '0;
               end
            end
            ST_CHECK: begin
               if (mismatch) begin
                  err_cnt <= err_cnt + 1'b1;
                  if (!fail_valid) begin
                     first_fail <= idx;
                     fail_valid <= 1'b1;
                  end
               end
               if (idx == IDX_LAST) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end else begin
                  idx  <= idx + 1'b1;
                  stim <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               done <= 1'b0;
               pass <= (err_cnt == '0);
            end
            default: ;
         endcase
      end
   end

endmodule
